csr_bank: RTL

//  Parametrised machine-mode CSR file, successor to the single-port CSR block.
//  - Executes CSRRW/CSRRS/CSRRC read-modify-write internally.
//  - Sequences trap entry and MRET in hardware: mepc/mcause/mstatus MIE<->MPIE.
//  - Tracks pending interrupts in mip.
//  - Provides 64-bit cycle/instret counters plus NUM_HPM event counters, with inhibit.

---
 rtl/csr_bank.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/csr_bank.sv
// Machine-mode CSR file: internal CSRRW/S/C read-modify-write, hardware trap/MRET
// sequencing, registered interrupt pending bits and inhibitable 64-bit event counters.
module csr_bank #(
    parameter int          NUM_HPM   = 2,
    parameter int          CNT_W     = 64,
    parameter logic [31:0] MTVEC_RST = 32'h0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [11:0]                         rd_addr_i,
    output logic [31:0]                         rd_data_o,
    input  logic                                ex_we_i,
    input  logic [1:0]                          ex_op_i,
    input  logic [11:0]                         ex_addr_i,
    input  logic [31:0]                         ex_wdata_i,
    output logic                                ex_illegal_o,
    input  logic                                trap_i,
    input  logic [31:0]                         trap_cause_i,
    input  logic [31:0]                         trap_pc_i,
    input  logic                                mret_i,
    input  logic [2:0]                          irq_i,
    input  logic                                instret_i,
    input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event_i,
    output logic [31:0]                         mtvec_o,
    output logic [31:0]                         mepc_o,
    output logic                                irq_pending_o
);

    localparam int          NUM_CNT  = 2 + NUM_HPM;
    localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
    localparam logic [31:0] HI_MASK  = 32'((64'h1 << (CNT_W - 32)) - 64'h1);

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MCNTINH  = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    logic              mstatus_mie_q, mstatus_mie_d;
    logic              mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0]       mie_q, mie_d;
    logic [31:0]       mtvec_q, mtvec_d;
    logic [31:0]       mcountinhibit_q, mcountinhibit_d;
    logic [31:0]       mscratch_q, mscratch_d;
    logic [31:0]       mepc_q, mepc_d;
    logic [31:0]       mcause_q, mcause_d;
    logic [2:0]        irq_q, irq_d;
    logic [31:0]       mip_val;
    logic [CNT_W-1:0]  cnt_val [NUM_CNT];

    logic [31:0]       ex_old, ex_rmw, ex_new;
    logic              ex_writable, ex_wr;

    // Counter k sits at address offset 0, 2, 3.. and uses the same bit in mcountinhibit.
    function automatic logic [7:0] cnt_off(input int k);
        return (k == 0) ? 8'h00 : (k == 1) ? 8'h02 : 8'(k + 1);
    endfunction

    function automatic logic [31:0] read_csr(input logic [11:0] addr);
        logic [31:0] v;
        case (addr)
            CSR_MSTATUS:  v = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
            CSR_MIE:      v = mie_q;
            CSR_MTVEC:    v = mtvec_q;
            CSR_MCNTINH:  v = mcountinhibit_q;
            CSR_MSCRATCH: v = mscratch_q;
            CSR_MEPC:     v = mepc_q;
            CSR_MCAUSE:   v = mcause_q;
            CSR_MIP:      v = mip_val;
            default:      v = '0;
        endcase
        for (int k = 0; k < NUM_CNT; k++) begin
            if (addr == {4'hB, cnt_off(k)} || (k < 2 && addr == {4'hC, cnt_off(k)}))
                v = cnt_val[k][31:0];
            if (addr == {4'hB, 8'h80 | cnt_off(k)} || (k < 2 && addr == {4'hC, 8'h80 | cnt_off(k)}))
                v = 32'(cnt_val[k] >> 32);
        end
        return v;
    endfunction

    function automatic logic is_writable(input logic [11:0] addr);
        logic w;
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MCNTINH,
            CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE: w = 1'b1;
            default:                            w = 1'b0;
        endcase
        for (int k = 0; k < NUM_CNT; k++) begin
            if (addr == {4'hB, cnt_off(k)} || addr == {4'hB, 8'h80 | cnt_off(k)})
                w = 1'b1;
        end
        return w;
    endfunction

    // The bypassed value is the one that will read back, so unimplemented bits are dropped here.
    function automatic logic [31:0] wr_mask(input logic [11:0] addr, input logic [31:0] v);
        logic [31:0] m;
        case (addr)
            CSR_MSTATUS: m = v & 32'h0000_0088;
            CSR_MCNTINH: m = v & INH_MASK;
            CSR_MEPC:    m = v & 32'hFFFF_FFFC;
            default:     m = (addr[11:8] == 4'hB && addr[7]) ? (v & HI_MASK) : v;
        endcase
        return m;
    endfunction

    assign mip_val       = {20'b0, irq_q[2], 3'b0, irq_q[1], 3'b0, irq_q[0], 3'b0};
    assign irq_pending_o = mstatus_mie_q & (|(mie_q & mip_val));
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;

    always_comb begin
        ex_old = read_csr(ex_addr_i);
        case (ex_op_i)
            2'b01:   ex_rmw = ex_wdata_i;
            2'b10:   ex_rmw = ex_old | ex_wdata_i;
            2'b11:   ex_rmw = ex_old & ~ex_wdata_i;
            default: ex_rmw = ex_old;
        endcase
        ex_new       = wr_mask(ex_addr_i, ex_rmw);
        ex_writable  = is_writable(ex_addr_i);
        ex_illegal_o = ex_we_i & ~ex_writable;
        ex_wr        = ex_we_i & ex_writable & (ex_op_i != 2'b00) & ~trap_i & ~mret_i;
        rd_data_o    = (ex_we_i && ex_writable && ex_addr_i == rd_addr_i) ? ex_new
                                                                          : read_csr(rd_addr_i);
    end

    always_comb begin
        mstatus_mie_d   = mstatus_mie_q;
        mstatus_mpie_d  = mstatus_mpie_q;
        mie_d           = mie_q;
        mtvec_d         = mtvec_q;
        mcountinhibit_d = mcountinhibit_q;
        mscratch_d      = mscratch_q;
        mepc_d          = mepc_q;
        mcause_d        = mcause_q;
        irq_d           = irq_i;
        if (trap_i) begin
            mepc_d         = trap_pc_i & 32'hFFFF_FFFC;
            mcause_d       = trap_cause_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (ex_wr) begin
            case (ex_addr_i)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = ex_new[3];
                    mstatus_mpie_d = ex_new[7];
                end
                CSR_MIE:      mie_d           = ex_new;
                CSR_MTVEC:    mtvec_d         = ex_new;
                CSR_MCNTINH:  mcountinhibit_d = ex_new;
                CSR_MSCRATCH: mscratch_d      = ex_new;
                CSR_MEPC:     mepc_d          = ex_new;
                CSR_MCAUSE:   mcause_d        = ex_new;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q   <= 1'b0;
            mstatus_mpie_q  <= 1'b0;
            mie_q           <= '0;
            mtvec_q         <= MTVEC_RST;
            mcountinhibit_q <= '0;
            mscratch_q      <= '0;
            mepc_q          <= '0;
            mcause_q        <= '0;
            irq_q           <= '0;
        end else begin
            mstatus_mie_q   <= mstatus_mie_d;
            mstatus_mpie_q  <= mstatus_mpie_d;
            mie_q           <= mie_d;
            mtvec_q         <= mtvec_d;
            mcountinhibit_q <= mcountinhibit_d;
            mscratch_q      <= mscratch_d;
            mepc_q          <= mepc_d;
            mcause_q        <= mcause_d;
            irq_q           <= irq_d;
        end
    end

    // Index 0 = mcycle, 1 = minstret, 2.. = mhpmcounter3..
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        localparam logic [7:0] OFF     = cnt_off(gi);
        localparam int         INH_BIT = (gi == 0) ? 0 : (gi == 1) ? 2 : gi + 1;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             inc, wr_lo, wr_hi;

        if (gi == 0) begin : g_cycle
            assign inc = 1'b1;
        end else if (gi == 1) begin : g_instret
            assign inc = instret_i;
        end else begin : g_hpm
            assign inc = hpm_event_i[gi-2];
        end

        assign wr_lo = ex_wr & (ex_addr_i == {4'hB, OFF});
        assign wr_hi = ex_wr & (ex_addr_i == {4'hB, 8'h80 | OFF});

        always_comb begin
            cnt_d = cnt_q;
            if (wr_lo)
                cnt_d[31:0] = ex_new;
            else if (wr_hi)
                cnt_d[CNT_W-1:32] = ex_new[CNT_W-33:0];
            else if (inc && !mcountinhibit_q[INH_BIT])
                cnt_d = cnt_q + CNT_W'(1);
        end

        always_ff @(posedge clk) begin
            if (rst)
                cnt_q <= '0;
            else
                cnt_q <= cnt_d;
        end

        assign cnt_val[gi] = cnt_q;
    end

endmodule
